// File: rtl/complex_matrix_deserializer.sv
// -----------------------------------------------------------------------------
// complex_matrix_deserializer
//
// Collects a matrix that arrives one complex element per AXI-Stream beat in
// row-major order and presents it as one wide matrix word on an AXI-Stream
// master. One instance sits in front of each operand port of the parallel
// complex matrix adder.
//
// Element k (k = row*MAT_WIDTH + col) lands at
// m_axis_tdata[(k+1)*ELEMENT_SIZE-1 : k*ELEMENT_SIZE]. Elements pass through
// unmodified: the upper half is real and the lower half is imaginary.
//
// Optional feature macro: CMM_DESER_FRAME_CHECK_EN
//   defined   : s_axis_tlast may close a matrix early, and the missing
//               elements read 0. A tlast on any beat other than N-1, or a
//               missing tlast on beat N-1, sets the sticky err_frame flag.
//   undefined : s_axis_tlast has no framing effect. A matrix always closes
//               after exactly N elements, and err_frame is tied to 0.
//
// Ports
//   clk            in   clock
//   reset_n        in   asynchronous, active-low reset
//   s_axis_tdata   in   [ELEMENT_SIZE-1:0] one complex element
//   s_axis_tvalid  in   element valid
//   s_axis_tready  out  element accepted when high together with tvalid
//   s_axis_tlast   in   marks the last element of a matrix
//   s_axis_tuser   in   per-matrix sideband, sampled on element 0
//   m_axis_tdata   out  [N*ELEMENT_SIZE-1:0] assembled matrix
//   m_axis_tvalid  out  matrix valid
//   m_axis_tready  in   downstream accept
//   m_axis_tlast   out  s_axis_tlast captured on the closing beat
//   m_axis_tuser   out  s_axis_tuser captured on element 0
//   err_frame      out  sticky framing error (0 when the check is compiled out)
//
// Handshake rule, on both ports: a transfer happens on a rising clk edge
// where valid and ready are both high. A master holds its valid and payload
// stable until that transfer occurs. s_axis_tready comes from registers only,
// so there is no combinational path from m_axis_tready to s_axis_tready.
// -----------------------------------------------------------------------------
module complex_matrix_deserializer #(
  parameter int MAT_WIDTH    = 4,
  parameter int MAT_HEIGHT   = 4,
  parameter int ELEMENT_SIZE = 16
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic [ELEMENT_SIZE-1:0]                       s_axis_tdata,
  input  logic                                          s_axis_tvalid,
  output logic                                          s_axis_tready,
  input  logic                                          s_axis_tlast,
  input  logic                                          s_axis_tuser,
  output logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0]  m_axis_tdata,
  output logic                                          m_axis_tvalid,
  input  logic                                          m_axis_tready,
  output logic                                          m_axis_tlast,
  output logic                                          m_axis_tuser,
  output logic                                          err_frame
);

  localparam int N     = MAT_WIDTH * MAT_HEIGHT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int DW    = N * ELEMENT_SIZE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // FILL collects elements. FULL presents the assembled word until it is taken.
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [DW-1:0]     data_buf;
  logic              tlast_q;
  logic              tuser_q;
  logic              run_q;       // low during reset, high from the first edge after release
  logic              s_hs;
  logic              m_hs;
  logic              at_last;
  logic              closing;

  // ---------------------------------------------------------------------------
  // Handshake and closing-beat decode
  // ---------------------------------------------------------------------------
  // run_q keeps s_axis_tready low while reset_n is low, even though the state
  // register already reads FILL at that point.
  assign s_axis_tready = run_q && (state == FILL);
  assign m_axis_tvalid = (state == FULL);

  assign s_hs    = s_axis_tvalid && s_axis_tready;
  assign m_hs    = m_axis_tvalid && m_axis_tready;
  assign at_last = (idx == LAST_IDX);

`ifdef CMM_DESER_FRAME_CHECK_EN
  // An early tlast also closes the matrix.
  assign closing = s_hs && (at_last || s_axis_tlast);
`else
  assign closing = s_hs && at_last;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FILL;
      run_q <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (closing) state_nxt = FULL;
      FULL:    if (m_hs)    state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Element index: wraps to 0 on the closing beat, so the next matrix always
  // starts at element 0. This includes an early close.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx <= '0;
    end else if (s_hs) begin
      if (closing) idx <= '0;
      else         idx <= idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Matrix buffer. Writes happen only in FILL, so the word is stable in FULL.
  // The buffer is cleared when the word is taken. This makes the elements
  // that an early-closed matrix never wrote read 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_buf <= '0;
    end else if (m_hs) begin
      data_buf <= '0;
    end else if (s_hs) begin
      data_buf[int'(idx)*ELEMENT_SIZE +: ELEMENT_SIZE] <= s_axis_tdata;
    end
  end

  assign m_axis_tdata = data_buf;

  // ---------------------------------------------------------------------------
  // Sideband. Both registers keep their values across the output handshake.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tlast_q <= 1'b0;
      tuser_q <= 1'b0;
    end else begin
      if (s_hs && (idx == '0)) tuser_q <= s_axis_tuser;
      if (closing)             tlast_q <= s_axis_tlast;
    end
  end

  assign m_axis_tlast = tlast_q;
  assign m_axis_tuser = tuser_q;

  // ---------------------------------------------------------------------------
  // Framing error
  // ---------------------------------------------------------------------------
`ifdef CMM_DESER_FRAME_CHECK_EN
  logic err_q;

  // Flags a tlast that arrives early, or a tlast missing on element N-1.
  // Once set, it stays set until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (s_hs && (s_axis_tlast != at_last)) begin
      err_q <= 1'b1;
    end
  end

  assign err_frame = err_q;
`else
  assign err_frame = 1'b0;
`endif

endmodule

// File: tb/tb_complex_matrix_deserializer.sv
// -----------------------------------------------------------------------------
// tb_complex_matrix_deserializer
//
// Directed bench for complex_matrix_deserializer in its default 4x4, 16-bit
// configuration. The bench builds every expected matrix word itself from the
// element values it sends. It checks reset values, output latency and
// duration, ready behaviour between matrices, backpressure, valid gaps,
// reset in the middle of a matrix, and the early-tlast behaviour for the
// build in use.
// -----------------------------------------------------------------------------
module tb_complex_matrix_deserializer;

  localparam int MW = 4;
  localparam int MH = 4;
  localparam int ES = 16;
  localparam int N  = MW * MH;
  localparam int DW = N * ES;

  logic          clk;
  logic          reset_n;
  logic [ES-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          s_axis_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          err_frame;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_word;
  int            stall;

  complex_matrix_deserializer #(
    .MAT_WIDTH   (MW),
    .MAT_HEIGHT  (MH),
    .ELEMENT_SIZE(ES)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .err_frame    (err_frame)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference word: element k = base + step*k (truncated to ES bits) for
  // k < count; the remaining elements are 0.
  function automatic logic [DW-1:0] ref_word(input int base, input int step, input int count);
    logic [DW-1:0] w;
    logic [ES-1:0] e;
    w = '0;
    for (int k = 0; k < count; k++) begin
      e = ES'(base + step * k);
      w[k*ES +: ES] = e;
    end
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Drivers. All driving happens 1 ns after a rising edge.
  // ---------------------------------------------------------------------------
  // Send one element and return just after the edge that accepts it. The
  // number of cycles spent waiting for ready is returned in stall_o.
  task automatic send_elem(input logic [ES-1:0] d, input logic last, input logic user,
                           input bit gaps, output int stall_o);
    int waited;
    if (gaps) begin
      repeat ($urandom_range(0, 1)) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    waited = 0;
    while (!s_axis_tready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 100) check("ready_timeout", DW'(0), DW'(1));
    @(posedge clk); #1;
    stall_o = waited;
  endtask

  // Send elements 0..count-1 with value base+step*k. tuser is driven only on
  // element 0, and tlast only on element last_beat. The task returns 1 ns
  // after the edge that accepts the final element, with s_axis_tvalid low.
  task automatic send_matrix(input int base, input int step, input int count, input int last_beat,
                             input logic user, input bit gaps, output int first_stall);
    int st;
    first_stall = 0;
    for (int k = 0; k < count; k++) begin
      send_elem(ES'(base + step * k), (k == last_beat), (k == 0) ? user : 1'b0, gaps, st);
      if (k == 0) first_stall = st;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset_n       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    m_axis_tready = 1'b1;

    // Reset values while reset_n is low.
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", DW'(s_axis_tready), DW'(0));
    check("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    check("rst_m_tdata",  m_axis_tdata,       DW'(0));
    check("rst_m_tlast",  DW'(m_axis_tlast),  DW'(0));
    check("rst_m_tuser",  DW'(m_axis_tuser),  DW'(0));
    check("rst_err",      DW'(err_frame),     DW'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_s_tready", DW'(s_axis_tready), DW'(1));

    // Test 1: elements 0..15 at full rate.
    exp_q.push_back(ref_word(0, 1, N));
    send_matrix(0, 1, N, N - 1, 1'b0, 1'b0, stall);
    exp_word = exp_q.pop_front();
    check("t1_m_tvalid", DW'(m_axis_tvalid), DW'(1));
    check("t1_s_tready", DW'(s_axis_tready), DW'(0));
    check("t1_m_tdata",  m_axis_tdata,       exp_word);
    check("t1_m_tlast",  DW'(m_axis_tlast),  DW'(1));
    check("t1_err",      DW'(err_frame),     DW'(0));
    @(posedge clk); #1;
    check("t1_tvalid_one_cycle", DW'(m_axis_tvalid), DW'(0));
    check("t1_ready_back",       DW'(s_axis_tready), DW'(1));

    // Test 2: two back-to-back matrices, tuser 1 then 0.
    exp_q.push_back(ref_word(16'h0100, 1, N));
    exp_q.push_back(ref_word(16'h0200, 3, N));
    send_matrix(16'h0100, 1, N, N - 1, 1'b1, 1'b0, stall);
    exp_word = exp_q.pop_front();
    check("t2a_m_tdata", m_axis_tdata,      exp_word);
    check("t2a_m_tuser", DW'(m_axis_tuser), DW'(1));
    send_matrix(16'h0200, 3, N, N - 1, 1'b0, 1'b0, stall);
    check("t2_gap_cycles", DW'(stall), DW'(1));
    exp_word = exp_q.pop_front();
    check("t2b_m_tvalid", DW'(m_axis_tvalid), DW'(1));
    check("t2b_m_tdata",  m_axis_tdata,       exp_word);
    check("t2b_m_tuser",  DW'(m_axis_tuser),  DW'(0));
    @(posedge clk); #1;

    // Test 3: backpressure for 10 cycles while the next element waits.
    m_axis_tready = 1'b0;
    exp_q.push_back(ref_word(16'h0300, 1, N));
    send_matrix(16'h0300, 1, N, N - 1, 1'b0, 1'b0, stall);
    exp_word = exp_q.pop_front();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'h0400;
    for (int c = 0; c < 10; c++) begin
      check("t3_hold_s_tready", DW'(s_axis_tready), DW'(0));
      check("t3_hold_m_tvalid", DW'(m_axis_tvalid), DW'(1));
      check("t3_hold_m_tdata",  m_axis_tdata,       exp_word);
      @(posedge clk); #1;
    end
    m_axis_tready = 1'b1;
    exp_q.push_back(ref_word(16'h0400, 1, N));
    send_matrix(16'h0400, 1, N, N - 1, 1'b0, 1'b0, stall);
    exp_word = exp_q.pop_front();
    check("t3_next_m_tdata", m_axis_tdata, exp_word);
    @(posedge clk); #1;

    // Test 4: random valid gaps, elements 0x1111*k.
    exp_q.push_back(ref_word(0, 16'h1111, N));
    send_matrix(0, 16'h1111, N, N - 1, 1'b0, 1'b1, stall);
    exp_word = exp_q.pop_front();
    check("t4_m_tvalid", DW'(m_axis_tvalid), DW'(1));
    check("t4_m_tdata",  m_axis_tdata,       exp_word);
    @(posedge clk); #1;

    // Test 5: reset after 7 elements, then a full new matrix.
    send_matrix(16'h0600, 1, 7, -1, 1'b1, 1'b0, stall);
    reset_n = 1'b0;
    #1;
    check("t5_rst_m_tdata",   m_axis_tdata,        DW'(0));
    check("t5_rst_s_tready",  DW'(s_axis_tready),  DW'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(ref_word(16'h0700, 1, N));
    send_matrix(16'h0700, 1, N, N - 1, 1'b0, 1'b0, stall);
    exp_word = exp_q.pop_front();
    check("t5_m_tvalid", DW'(m_axis_tvalid), DW'(1));
    check("t5_m_tdata",  m_axis_tdata,       exp_word);
    check("t5_m_tuser",  DW'(m_axis_tuser),  DW'(0));
    @(posedge clk); #1;

    // Test 6: tlast on element 5 (elements 0xA0..0xA5).
`ifdef CMM_DESER_FRAME_CHECK_EN
    exp_q.push_back(ref_word(16'h00A0, 1, 6));
    send_matrix(16'h00A0, 1, 6, 5, 1'b0, 1'b0, stall);
    exp_word = exp_q.pop_front();
    check("t6_m_tvalid", DW'(m_axis_tvalid), DW'(1));
    check("t6_m_tdata",  m_axis_tdata,       exp_word);
    check("t6_m_tlast",  DW'(m_axis_tlast),  DW'(1));
    check("t6_err",      DW'(err_frame),     DW'(1));
    repeat (3) @(posedge clk);
    #1;
    check("t6_err_sticky", DW'(err_frame),     DW'(1));
    check("t6_ready_back", DW'(s_axis_tready), DW'(1));
`else
    send_matrix(16'h00A0, 1, 6, 5, 1'b0, 1'b0, stall);
    check("t6_no_early_out", DW'(m_axis_tvalid), DW'(0));
    check("t6_still_ready",  DW'(s_axis_tready), DW'(1));
    exp_q.push_back(ref_word(16'h00A0, 1, N));
    send_matrix(16'h00A6, 1, N - 6, N - 7, 1'b0, 1'b0, stall);
    exp_word = exp_q.pop_front();
    check("t6_m_tvalid", DW'(m_axis_tvalid), DW'(1));
    check("t6_m_tdata",  m_axis_tdata,       exp_word);
    check("t6_m_tlast",  DW'(m_axis_tlast),  DW'(1));
    check("t6_err",      DW'(err_frame),     DW'(0));
    @(posedge clk); #1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit, so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule
